// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared constants, FSM state type and saturation helper for adsr_cfg
//
// Contents:
//   ADSR_MAX     Q1.31 full-scale level (1.0)
//   DIV_W        width of the shared divider dividend/quotient
//   cfg_state_t  adsr_cfg controller states
//   sat32()      clamp a 48-bit cycle-count product to 32 bits

package adsr_pkg;

  localparam logic [31:0] ADSR_MAX = 32'h8000_0000;
  localparam int          DIV_W    = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_DIV_SUS,
    S_DIV_ATK,
    S_DIV_DEC,
    S_DIV_REL,
    S_LOAD
  } cfg_state_t;

  function automatic logic [31:0] sat32(input logic [47:0] p);
    return (|p[47:32]) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

endpackage

// File: rtl/udiv40.sv
// rtl/udiv40.sv - restoring divider, 40-bit dividend by 32-bit divisor, one quotient bit per clk
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   go            load dividend/divisor and start (40 iterations follow)
//   dividend      DIV_W-bit numerator, sampled on go
//   divisor       32-bit denominator, sampled on go; 0 gives an all-ones quotient
//   quotient      DIV_W-bit result, valid while done is high
//   done          one-cycle pulse after the last iteration

module udiv40
  import adsr_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [DIV_W-1:0] dividend,
  input  logic [31:0]      divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  logic [DIV_W-1:0] q;
  logic [31:0]      rem;
  logic [31:0]      dvs;
  logic [5:0]       cnt;
  logic [32:0]      trial;
  logic [32:0]      diff;
  logic             ge;

  // Dividend bits shift out of the top of q while quotient bits shift in at
  // the bottom. A zero divisor makes every trial succeed, hence all ones.
  always_comb begin
    trial = {rem, q[DIV_W-1]};
    ge    = (trial >= {1'b0, dvs});
    diff  = trial - {1'b0, dvs};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (go) begin
      q    <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= 6'(DIV_W);
      done <= 1'b0;
    end else if (cnt != 6'd0) begin
      q    <= {q[DIV_W-2:0], ge};
      rem  <= ge ? diff[31:0] : trial[31:0];
      cnt  <= cnt - 6'd1;
      done <= (cnt == 6'd1);
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = q;

endmodule

// File: rtl/adsr_cfg.sv
// rtl/adsr_cfg.sv - converts ADSR times/percentage into per-clock step words and gates the start pulse
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cfg_valid / cfg_ready        configuration handshake (ready only in IDLE)
//   attack/decay/release/sustain_ms, sustain_pct   configuration inputs
//   trig                         note trigger pulse
//   attack/decay/release_step, sustain_level, sustain_time   Q1.31 / cycle outputs
//   start                        one-cycle envelope start
//   upd                          one-cycle pulse when new outputs appear

module adsr_cfg
  import adsr_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 100_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [15:0] attack_ms,
  input  logic [15:0] decay_ms,
  input  logic [15:0] release_ms,
  input  logic [15:0] sustain_ms,
  input  logic [7:0]  sustain_pct,
  input  logic        trig,
  output logic [31:0] attack_step,
  output logic [31:0] decay_step,
  output logic [31:0] sustain_level,
  output logic [31:0] release_step,
  output logic [31:0] sustain_time,
  output logic        start,
  output logic        upd
);

  cfg_state_t state, state_nxt;

  logic [15:0] a_ms, d_ms, r_ms, s_ms;
  logic [7:0]  pct_q, pct_c;
  logic [31:0] na, nd, nr, ns;
  logic [31:0] sus_r, atk_r, dec_r, rel_r;
  logic        div_run, trig_pend;

  logic             div_go, div_done, in_div;
  logic [DIV_W-1:0] div_a, div_q;
  logic [31:0]      div_b, q_sat, step_val;

  udiv40 u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (div_go),
    .dividend (div_a),
    .divisor  (div_b),
    .quotient (div_q),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cfg_valid) state_nxt = S_CAP;
      S_CAP:     state_nxt = S_DIV_SUS;
      S_DIV_SUS: if (div_done) state_nxt = S_DIV_ATK;
      S_DIV_ATK: if (div_done) state_nxt = S_DIV_DEC;
      S_DIV_DEC: if (div_done) state_nxt = S_DIV_REL;
      S_DIV_REL: if (div_done) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Operand select for the shared divider. Sustain level is computed first
  // because decay and release both divide quantities derived from it.
  always_comb begin
    div_a  = '0;
    div_b  = '0;
    in_div = 1'b1;
    case (state)
      S_DIV_SUS: begin
        div_a = {1'b0, pct_c, 31'd0};
        div_b = 32'd100;
      end
      S_DIV_ATK: begin
        div_a = {8'd0, ADSR_MAX};
        div_b = na;
      end
      S_DIV_DEC: begin
        div_a = {8'd0, ADSR_MAX - sus_r};
        div_b = nd;
      end
      S_DIV_REL: begin
        div_a = {8'd0, sus_r};
        div_b = nr;
      end
      default: in_div = 1'b0;
    endcase
  end

  // The divide still runs for a zero-length phase so every phase costs the
  // same number of cycles; only the stored result is replaced by MAX.
  always_comb begin
    div_go   = in_div && !div_run;
    q_sat    = (|div_q[DIV_W-1:32]) ? 32'hFFFF_FFFF : div_q[31:0];
    step_val = (div_b == 32'd0) ? ADSR_MAX :
               (q_sat == 32'd0) ? 32'd1    : q_sat;
  end

  assign cfg_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_ms          <= '0;
      d_ms          <= '0;
      r_ms          <= '0;
      s_ms          <= '0;
      pct_q         <= '0;
      pct_c         <= '0;
      na            <= '0;
      nd            <= '0;
      nr            <= '0;
      ns            <= '0;
      sus_r         <= '0;
      atk_r         <= ADSR_MAX;
      dec_r         <= ADSR_MAX;
      rel_r         <= ADSR_MAX;
      div_run       <= 1'b0;
      trig_pend     <= 1'b0;
      attack_step   <= ADSR_MAX;
      decay_step    <= ADSR_MAX;
      release_step  <= ADSR_MAX;
      sustain_level <= '0;
      sustain_time  <= '0;
      start         <= 1'b0;
      upd           <= 1'b0;
    end else begin
      // Inputs are taken on the accepting edge; the source may change them
      // as soon as the transfer completes.
      if (state == S_IDLE && cfg_valid) begin
        a_ms  <= attack_ms;
        d_ms  <= decay_ms;
        r_ms  <= release_ms;
        s_ms  <= sustain_ms;
        pct_q <= sustain_pct;
      end

      if (state == S_CAP) begin
        na    <= sat32(48'(a_ms) * 48'(CLK_PER_MS));
        nd    <= sat32(48'(d_ms) * 48'(CLK_PER_MS));
        nr    <= sat32(48'(r_ms) * 48'(CLK_PER_MS));
        ns    <= sat32(48'(s_ms) * 48'(CLK_PER_MS));
        pct_c <= (pct_q > 8'd100) ? 8'd100 : pct_q;
      end

      if (div_go)        div_run <= 1'b1;
      else if (div_done) div_run <= 1'b0;

      if (div_done) begin
        case (state)
          S_DIV_SUS: sus_r <= q_sat;
          S_DIV_ATK: atk_r <= step_val;
          S_DIV_DEC: dec_r <= step_val;
          S_DIV_REL: rel_r <= step_val;
          default: ;
        endcase
      end

      upd <= (state == S_LOAD);
      if (state == S_LOAD) begin
        attack_step   <= atk_r;
        decay_step    <= dec_r;
        release_step  <= rel_r;
        sustain_level <= sus_r;
        sustain_time  <= ns;
      end

      // Triggers seen while busy (including on the LOAD edge) are held and
      // released as a single start once back in IDLE with the new words.
      start     <= (state == S_IDLE) && (trig || trig_pend);
      trig_pend <= (state != S_IDLE) && (trig || trig_pend);
    end
  end

endmodule

// File: tb/tb_adsr_cfg.sv
// tb/tb_adsr_cfg.sv - self-checking bench for adsr_cfg against an arithmetic reference model

module tb_adsr_cfg;

  typedef struct packed {
    logic [31:0] atk;
    logic [31:0] dec;
    logic [31:0] sus;
    logic [31:0] rel;
    logic [31:0] st;
  } res_t;

  localparam res_t RST = {32'h8000_0000, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] attack_ms = '0, decay_ms = '0, release_ms = '0, sustain_ms = '0;
  logic [7:0]  sustain_pct = '0;

  logic        a_ready, a_start, a_upd, b_ready, b_start, b_upd;
  logic [31:0] a_atk, a_dec, a_sus, a_rel, a_st;
  logic [31:0] b_atk, b_dec, b_sus, b_rel, b_st;
  res_t        out_a, out_b;

  assign out_a = {a_atk, a_dec, a_sus, a_rel, a_st};
  assign out_b = {b_atk, b_dec, b_sus, b_rel, b_st};

  adsr_cfg #(.CLK_PER_MS(10)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(a_ready),
    .attack_ms(attack_ms), .decay_ms(decay_ms), .release_ms(release_ms),
    .sustain_ms(sustain_ms), .sustain_pct(sustain_pct), .trig(trig),
    .attack_step(a_atk), .decay_step(a_dec), .sustain_level(a_sus),
    .release_step(a_rel), .sustain_time(a_st), .start(a_start), .upd(a_upd)
  );

  adsr_cfg #(.CLK_PER_MS(100_000)) dut_big (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(b_ready),
    .attack_ms(attack_ms), .decay_ms(decay_ms), .release_ms(release_ms),
    .sustain_ms(sustain_ms), .sustain_pct(sustain_pct), .trig(trig),
    .attack_step(b_atk), .decay_step(b_dec), .sustain_level(b_sus),
    .release_step(b_rel), .sustain_time(b_st), .start(b_start), .upd(b_upd)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  bit   trig_at [0:255];
  res_t prev_a, prev_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string who, input res_t got, input res_t exp);
    check({who, ".attack_step"},   64'(got.atk), 64'(exp.atk));
    check({who, ".decay_step"},    64'(got.dec), 64'(exp.dec));
    check({who, ".sustain_level"}, 64'(got.sus), 64'(exp.sus));
    check({who, ".release_step"},  64'(got.rel), 64'(exp.rel));
    check({who, ".sustain_time"},  64'(got.st),  64'(exp.st));
  endtask

  // Reference model: plain wide arithmetic straight from the conversion rules.
  function automatic logic [31:0] cycles(input logic [63:0] ms, input logic [63:0] cpm);
    logic [63:0] p;
    p = ms * cpm;
    return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

  function automatic logic [31:0] step(input logic [63:0] num, input logic [31:0] n);
    logic [63:0] q;
    if (n == 32'd0) return 32'h8000_0000;
    q = num / {32'd0, n};
    if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    if (q == 64'd0) return 32'd1;
    return q[31:0];
  endfunction

  function automatic res_t model(input logic [63:0] a, input logic [63:0] d, input logic [63:0] r,
                                 input logic [63:0] s, input logic [63:0] pct, input logic [63:0] cpm);
    logic [63:0] pc, sl;
    res_t m;
    pc    = (pct > 64'd100) ? 64'd100 : pct;
    sl    = (pc * 64'h8000_0000) / 64'd100;
    m.sus = sl[31:0];
    m.atk = step(64'h8000_0000, cycles(a, cpm));
    m.dec = step(64'h8000_0000 - sl, cycles(d, cpm));
    m.rel = step(sl, cycles(r, cpm));
    m.st  = cycles(s, cpm);
    return m;
  endfunction

  task automatic run_cfg(input int unsigned a, input int unsigned d, input int unsigned r,
                         input int unsigned s, input int unsigned pct);
    res_t ea, eb;
    int   upd_k, nstart;
    bit   early, exp_start;
    ea = model(64'(a), 64'(d), 64'(r), 64'(s), 64'(pct), 64'd10);
    eb = model(64'(a), 64'(d), 64'(r), 64'(s), 64'(pct), 64'd100_000);
    exp_start = 1'b0;
    for (int i = 0; i < 256; i++) if (trig_at[i]) exp_start = 1'b1;

    @(negedge clk);
    check("cfg_ready_idle", 64'(a_ready), 64'd1);
    attack_ms = 16'(a); decay_ms = 16'(d); release_ms = 16'(r);
    sustain_ms = 16'(s); sustain_pct = 8'(pct);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid   = 1'b0;
    attack_ms   = 16'($urandom); decay_ms = 16'($urandom);
    release_ms  = 16'($urandom); sustain_ms = 16'($urandom);
    sustain_pct = 8'($urandom);
    trig        = trig_at[1];

    upd_k = -1; nstart = 0; early = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (a_upd) begin
        upd_k = k;
        break;
      end
      if (out_a !== prev_a || out_b !== prev_b || b_upd) early = 1'b1;
      if (a_start || b_start) nstart++;
      if (k == 5) check("cfg_ready_busy", 64'(a_ready), 64'd0);
      trig = trig_at[k+1];
    end
    trig = 1'b0;

    check("upd_edge", 64'(upd_k), 64'd170);
    check("upd_big", 64'(b_upd), 64'd1);
    check("outputs_early_change", 64'(early), 64'd0);
    check("start_while_busy", 64'(nstart), 64'd0);
    check_res("clk10", out_a, ea);
    check_res("clk100k", out_b, eb);

    @(posedge clk); #1;
    check("start_after_upd", 64'(a_start), 64'(exp_start));
    check("start_after_upd_big", 64'(b_start), 64'(exp_start));
    check("upd_single", 64'(a_upd), 64'd0);
    @(posedge clk); #1;
    check("start_single", 64'(a_start), 64'd0);

    prev_a = ea;
    prev_b = eb;
    for (int i = 0; i < 256; i++) trig_at[i] = 1'b0;
  endtask

  function automatic int unsigned rand_ms();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return $urandom_range(0, 65535);
      default: return $urandom_range(1, 100);
    endcase
  endfunction

  initial begin
    int nbad;
    for (int i = 0; i < 256; i++) trig_at[i] = 1'b0;
    prev_a = RST;
    prev_b = RST;

    repeat (3) @(negedge clk);
    check_res("reset", out_a, RST);
    check("reset.cfg_ready", 64'(a_ready), 64'd1);
    check("reset.start", 64'(a_start), 64'd0);
    check("reset.upd", 64'(a_upd), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_cfg(2, 1, 4, 3, 50);
    check("ex1.sustain_level", 64'(a_sus), 64'h4000_0000);
    check("ex1.attack_step",   64'(a_atk), 64'h0666_6666);
    check("ex1.decay_step",    64'(a_dec), 64'h0666_6666);
    check("ex1.release_step",  64'(a_rel), 64'h0199_9999);
    check("ex1.sustain_time",  64'(a_st),  64'h1E);

    run_cfg(0, 0, 0, 0, 0);
    check("zero.attack_step",   64'(a_atk), 64'h8000_0000);
    check("zero.decay_step",    64'(a_dec), 64'h8000_0000);
    check("zero.release_step",  64'(a_rel), 64'h8000_0000);
    check("zero.sustain_level", 64'(a_sus), 64'h0);
    check("zero.sustain_time",  64'(a_st),  64'h0);

    run_cfg(3, 5, 7, 2, 200);
    check("pct200.sustain_level", 64'(a_sus), 64'h8000_0000);
    check("pct200.decay_step",    64'(a_dec), 64'd1);
    check("pct200.release_step",  64'(a_rel), 64'h8000_0000 / 64'd70);

    run_cfg(1, 1, 1, 65535, 30);
    check("sat.sustain_time_100k", 64'(b_st), 64'hFFFF_FFFF);

    trig_at[10] = 1'b1; trig_at[60] = 1'b1; trig_at[150] = 1'b1;
    run_cfg(6, 2, 9, 4, 75);

    trig_at[170] = 1'b1;
    run_cfg(1, 3, 2, 5, 100);

    @(posedge clk); #1;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    check("idle_trig.start", 64'(a_start), 64'd1);
    @(posedge clk); #1;
    check("idle_trig.single", 64'(a_start), 64'd0);

    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 1) == 1) trig_at[$urandom_range(1, 170)] = 1'b1;
      run_cfg(rand_ms(), rand_ms(), rand_ms(), rand_ms(), $urandom_range(0, 255));
    end

    @(negedge clk);
    attack_ms = 16'd5; decay_ms = 16'd5; release_ms = 16'd5;
    sustain_ms = 16'd5; sustain_pct = 8'd40;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      trig = (k == 9);
      @(posedge clk); #1;
    end
    trig = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_res("midreset", out_a, RST);
    check("midreset.cfg_ready", 64'(a_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    nbad = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (a_start || a_upd || !a_ready) nbad++;
    end
    check("midreset.no_start_upd", 64'(nbad), 64'd0);
    check_res("midreset.after", out_a, RST);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
